// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-addressed data memory responder with fixed-latency response
//
// Purpose: RV32I-style load/store memory. A request is accepted when
// req_valid_i && req_ready_o. Stores commit and load data is captured on that
// edge. resp_valid_o then pulses LATENCY cycles later.
//
// Optional feature: macro DMEM_MISALIGN_CHECK_EN.
//   Defined   - misaligned H/W requests do not write storage and respond with
//               resp_err_o=1 and resp_rdata_o=0.
//   Undefined - low address bits are forced to alignment and resp_err_o is 0.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  responder can accept a request (low while waiting)
//   req_we_i     1 = store, 0 = load
//   req_funct3_i size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (others = W)
//   req_addr_i   byte address (upper bits beyond MEM_ADDR_WIDTH ignored)
//   req_wdata_i  store data, LSB-aligned
//   resp_valid_o one-cycle response strobe
//   resp_rdata_o load result, 0 for stores and whenever resp_valid_o is 0
//   resp_err_o   misaligned-access flag, qualified by resp_valid_o
//   busy_o       pipeline stall request
module dmem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int LATENCY        = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  busy_o
);

  localparam int MEM_BYTES = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  // Storage is deliberately never reset.
  logic [7:0]              mem [MEM_BYTES];

  logic                      accept;
  logic                      is_byte, is_half, is_word, is_unsigned;
  logic                      bad;
  logic [MEM_ADDR_WIDTH-1:0] addr_raw, addr_eff, addr_p1, addr_p2, addr_p3;
  logic [7:0]                b0, b1, b2, b3;
  logic [DATA_WIDTH-1:0]     load_data;
  logic                      unused_addr_bits;

  // Address bits above the storage size wrap around.
  assign unused_addr_bits = ^req_addr_i[DATA_WIDTH-1:MEM_ADDR_WIDTH];
  assign addr_raw         = req_addr_i[MEM_ADDR_WIDTH-1:0];

  // Size decode: reserved codes 011/110/111 fall into the word case.
  assign is_byte     = (req_funct3_i[1:0] == 2'b00);
  assign is_half     = (req_funct3_i[1:0] == 2'b01);
  assign is_word     = !is_byte && !is_half;
  assign is_unsigned = req_funct3_i[2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad      = (is_half && addr_raw[0]) || (is_word && (addr_raw[1:0] != 2'b00));
  assign addr_eff = addr_raw;
`else
  assign bad = 1'b0;
  always_comb begin
    addr_eff = addr_raw;
    if (is_half) addr_eff[0] = 1'b0;
    if (is_word) addr_eff[1:0] = 2'b00;
  end
`endif

  assign addr_p1 = addr_eff + MEM_ADDR_WIDTH'(1);
  assign addr_p2 = addr_eff + MEM_ADDR_WIDTH'(2);
  assign addr_p3 = addr_eff + MEM_ADDR_WIDTH'(3);

  assign b0 = mem[addr_eff];
  assign b1 = mem[addr_p1];
  assign b2 = mem[addr_p2];
  assign b3 = mem[addr_p3];

  always_comb begin
    load_data = '0;
    if (bad) begin
      load_data = '0;
    end else if (is_byte) begin
      if (is_unsigned) load_data = DATA_WIDTH'(b0);
      else             load_data = DATA_WIDTH'($signed(b0));
    end else if (is_half) begin
      if (is_unsigned) load_data = DATA_WIDTH'({b1, b0});
      else             load_data = DATA_WIDTH'($signed({b1, b0}));
    end else begin
      load_data = DATA_WIDTH'({b3, b2, b1, b0});
    end
  end

  assign req_ready_o = rst_i && (state_q != ST_WAIT);
  assign accept      = req_valid_i && req_ready_o;

  // Store commits on the acceptance edge, so a load accepted on any later
  // edge already sees the new bytes.
  always_ff @(posedge clk_i) begin
    if (accept && req_we_i && !bad) begin
      mem[addr_eff] <= req_wdata_i[7:0];
      if (!is_byte) begin
        mem[addr_p1] <= req_wdata_i[15:8];
      end
      if (is_word) begin
        mem[addr_p2] <= req_wdata_i[23:16];
        mem[addr_p3] <= req_wdata_i[31:24];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      default: begin
        // IDLE and RESP both accept; RESP can chain straight into a new request.
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
    endcase
    // Captured result is frozen until the next acceptance.
    if (accept) begin
      rdata_d = req_we_i ? '0 : load_data;
      err_d   = bad;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_err_o   = resp_valid_o && err_q;
  assign busy_o       = (state_q == ST_WAIT) ||
                        (req_valid_i && (state_q != ST_IDLE) && (state_q != ST_RESP));

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam logic       WE_ST = 1'b1;
  localparam logic       WE_LD = 1'b0;
  localparam logic [2:0] F_B   = 3'b000;
  localparam logic [2:0] F_H   = 3'b001;
  localparam logic [2:0] F_W   = 3'b010;
  localparam logic [2:0] F_BU  = 3'b100;
  localparam logic [2:0] F_HU  = 3'b101;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(
    .DATA_WIDTH    (32),
    .MEM_ADDR_WIDTH(12),
    .LATENCY       (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_funct3_i(req_funct3_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o),
    .resp_err_o  (resp_err_o),
    .busy_o      (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
  endtask

  // Present one request, release inputs right after acceptance (with junk
  // address/data), then count negedges until the response strobe.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    @(negedge clk_i);
    apply(we, f3, addr, wd);
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = 32'hFFFF_FFFF;
    req_wdata_i = $urandom;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!resp_valid_o && lat < 20);
    rd = resp_rdata_o;
    er = resp_err_o;
  endtask

  task automatic run_chk(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(we, f3, addr, wd, rd, er, lat);
    check({tag, "_data"}, rd, exp_rd);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    check({tag, "_lat"}, lat, 32'd2);
  endtask

  // Reset asserted in the WAIT cycle of a pending request.
  task automatic rst_mid(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
    int npulse;
    @(negedge clk_i);
    apply(we, F_W, addr, wd);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    @(negedge clk_i);
    check({tag, "_busy_wait"}, {31'b0, busy_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check({tag, "_valid_in_rst"}, {31'b0, resp_valid_o}, 32'd0);
    check({tag, "_busy_in_rst"}, {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    npulse = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (resp_valid_o) npulse++;
    end
    check({tag, "_dropped"}, npulse, 32'd0);
  endtask

  logic        s_we [5];
  logic [2:0]  s_f3 [5];
  logic [31:0] s_ad [5];
  logic [31:0] s_wd [5];
  logic [31:0] s_ex [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  k, nresp, nwait, last, first;
    logic acc;

    // Reset
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_err", {31'b0, resp_err_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);

    // Basic store/load and sub-word loads
    run_chk("sw10", WE_ST, F_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    run_chk("lw10", WE_LD, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    run_chk("lb13", WE_LD, F_B, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    run_chk("lbu13", WE_LD, F_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    run_chk("lh12", WE_LD, F_H, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    run_chk("lhu10", WE_LD, F_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    run_chk("lb10", WE_LD, F_B, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    run_chk("lh10", WE_LD, F_H, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    run_chk("lw1010_wrap", WE_LD, F_W, 32'h1010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte/half stores touch only their own bytes; reserved codes act as W
    run_chk("sw20", WE_ST, F_W, 32'h20, 32'h0, 32'h0, 1'b0);
    run_chk("sb20", WE_ST, F_B, 32'h20, 32'hFFFFFFAB, 32'h0, 1'b0);
    run_chk("sh22", WE_ST, F_H, 32'h22, 32'hFFFF1234, 32'h0, 1'b0);
    run_chk("lw20", WE_LD, F_W, 32'h20, 32'h0, 32'h123400AB, 1'b0);
    run_chk("f011", WE_LD, 3'b011, 32'h20, 32'h0, 32'h123400AB, 1'b0);
    run_chk("f110", WE_LD, 3'b110, 32'h20, 32'h0, 32'h123400AB, 1'b0);
    run_chk("f111", WE_LD, 3'b111, 32'h20, 32'h0, 32'h123400AB, 1'b0);

    // Back-to-back: store followed by four loads with valid held high
    s_we[0] = WE_ST; s_f3[0] = F_W;  s_ad[0] = 32'h30; s_wd[0] = 32'hCAFEF00D; s_ex[0] = 32'h0;
    s_we[1] = WE_LD; s_f3[1] = F_W;  s_ad[1] = 32'h30; s_wd[1] = 32'h0;       s_ex[1] = 32'hCAFEF00D;
    s_we[2] = WE_LD; s_f3[2] = F_W;  s_ad[2] = 32'h10; s_wd[2] = 32'h0;       s_ex[2] = 32'hDEADBEEF;
    s_we[3] = WE_LD; s_f3[3] = F_BU; s_ad[3] = 32'h13; s_wd[3] = 32'h0;       s_ex[3] = 32'h000000DE;
    s_we[4] = WE_LD; s_f3[4] = F_H;  s_ad[4] = 32'h12; s_wd[4] = 32'h0;       s_ex[4] = 32'hFFFFDEAD;
    @(negedge clk_i);
    apply(s_we[0], s_f3[0], s_ad[0], s_wd[0]);
    k = 0; nresp = 0; nwait = 0; last = 0; first = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (resp_valid_o) begin
        if (nresp < 5) check($sformatf("b2b_data%0d", nresp), resp_rdata_o, s_ex[nresp]);
        if (nresp > 0) check("b2b_gap", cyc - last, 32'd2);
        else first = cyc;
        last = cyc;
        nresp++;
      end else begin
        check("b2b_idle_rdata", resp_rdata_o, 32'd0);
        check("b2b_idle_err", {31'b0, resp_err_o}, 32'd0);
      end
      if (busy_o) begin
        check("b2b_wait_ready", {31'b0, req_ready_o}, 32'd0);
        nwait++;
      end
      acc = req_valid_i && req_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) begin
        k++;
        if (k < 5) apply(s_we[k], s_f3[k], s_ad[k], s_wd[k]);
        else req_valid_i = 1'b0;
      end
      @(negedge clk_i);
    end
    check("b2b_first_lat", first, 32'd2);
    check("b2b_nresp", nresp, 32'd5);
    check("b2b_nwait", nwait, 32'd5);

    // Reset during WAIT drops the response; storage and committed stores survive
    rst_mid("rst_lw", WE_LD, 32'h10, 32'h0);
    run_chk("rst_lw_after", WE_LD, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    rst_mid("rst_sw", WE_ST, 32'h40, 32'h55AA1234);
    run_chk("rst_sw_after", WE_LD, F_W, 32'h40, 32'h0, 32'h55AA1234, 1'b0);

    // Misaligned access
`ifdef DMEM_MISALIGN_CHECK_EN
    run_chk("sw11_mis", WE_ST, F_W, 32'h11, 32'h12345678, 32'h0, 1'b1);
    run_chk("lw10_kept", WE_LD, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    run_chk("lh11_mis", WE_LD, F_H, 32'h11, 32'h0, 32'h0, 1'b1);
`else
    run_chk("sw11_align", WE_ST, F_W, 32'h11, 32'h12345678, 32'h0, 1'b0);
    run_chk("lw10_new", WE_LD, F_W, 32'h10, 32'h0, 32'h12345678, 1'b0);
    run_chk("lh11_align", WE_LD, F_H, 32'h11, 32'h0, 32'h00005678, 1'b0);
    run_chk("lw13_align", WE_LD, F_W, 32'h13, 32'h0, 32'h12345678, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data and address buses.
REQ-002 Parameter MEM_ADDR_WIDTH, default 12, SHALL set the byte-addressed storage size (2^MEM_ADDR_WIDTH bytes).
REQ-003 Parameter LATENCY, default 2, range 1..15, SHALL set the number of cycles from request acceptance to response.
REQ-004 Ports SHALL be, in this order:
- clk_i  in  1  single clock; rising edge
- rst_i  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr_i  in  DATA_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  store data, LSB-aligned
- resp_valid_o  out  1  one-cycle response strobe
- resp_rdata_o  out  DATA_WIDTH  load result (0 for stores)
- resp_err_o  out  1  misaligned-access flag, valid with resp_valid_o
- busy_o  out  1  pipeline stall request

Function
REQ-005 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both 1.
REQ-006 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-007 In IDLE, accept -> WAIT with counter = LATENCY-1 if LATENCY>1; accept -> RESP if LATENCY=1; no accept -> IDLE.
REQ-008 In WAIT, the counter SHALL decrement each cycle, with the transition to RESP when it reaches 0.
REQ-009 In RESP, resp_valid_o SHALL be 1 for exactly one cycle, followed by IDLE, or WAIT/RESP per REQ-007 if a new request is accepted in the same cycle.
REQ-010 req_ready_o SHALL be 1 in IDLE and RESP and 0 in WAIT; busy_o SHALL equal (state==WAIT) or (req_valid_i and state!=IDLE and not RESP).
REQ-011 Response SHALL appear exactly LATENCY cycles after the acceptance edge; back-to-back requests SHALL sustain one response per LATENCY cycles.
REQ-012 Storage SHALL be little-endian bytes, indexed by req_addr_i[MEM_ADDR_WIDTH-1:0]; upper address bits SHALL be ignored (wrap-around).
REQ-013 A store SHALL commit on the acceptance edge: SB writes byte 0, SH writes bytes 0..1, SW writes bytes 0..3 of req_wdata_i.
REQ-014 Load data SHALL be captured on the acceptance edge and held in a register until the response: B/H sign-extended, BU/HU zero-extended, W unmodified.
REQ-015 A load accepted in the cycle after a store to the same address SHALL return the stored data.
REQ-016 Reserved funct3 codes (011, 110, 111) SHALL be treated as W.
REQ-017 Request inputs SHALL be ignored outside the acceptance edge; the captured request SHALL NOT change while in WAIT.
REQ-018 resp_rdata_o and resp_err_o SHALL be 0 whenever resp_valid_o is 0.

Reset
REQ-019 On rst_i=0, the FSM SHALL go to IDLE immediately.
REQ-020 While and after reset: counter=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, busy_o=0, and req_ready_o=1 once rst_i=1.
REQ-021 Reset during WAIT or RESP SHALL drop the pending response; a store already committed SHALL remain; storage contents SHALL NOT be cleared by reset.

Configuration
REQ-022 With macro DMEM_MISALIGN_CHECK_EN defined, misaligned requests SHALL NOT write storage. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-023 With DMEM_MISALIGN_CHECK_EN defined, a misaligned request SHALL still produce a response at normal latency, with resp_err_o=1 and resp_rdata_o=0.
REQ-024 Without DMEM_MISALIGN_CHECK_EN, resp_err_o SHALL be tied 0 and the low address bits SHALL be forced to alignment: addr[0] cleared for H, addr[1:0] cleared for W.

Verification
REQ-025 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata_o=0xDEADBEEF exactly 2 cycles after acceptance (LATENCY=2).
REQ-026 After REQ-025, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-027 req_valid_i held 1 for 4 loads with LATENCY=2 -> 4 resp_valid_o pulses two cycles apart, and req_ready_o=0 in every WAIT cycle.
REQ-028 Assert rst_i=0 during WAIT of a pending LW -> no resp_valid_o; after release, LW of the same address returns the prior contents.
REQ-029 With DMEM_MISALIGN_CHECK_EN, SW 0x11 data 0x12345678 -> resp_err_o=1, and LW 0x10 still returns 0xDEADBEEF; without the macro, the same SW writes 0x10 and LW 0x10 -> 0x12345678.
REQ-030 LW 0x1010 with MEM_ADDR_WIDTH=12 -> returns the same data as LW 0x010 (wrap-around).
